// File: rtl/qtz_pkg.sv
// Shared sizing and collector state encoding for the quantizer segment-mapping path.
package qtz_pkg;

  localparam int unsigned SEQ_CYCLE_COUNT = 4;
  localparam int unsigned CTR_W           = $clog2(SEQ_CYCLE_COUNT);
  localparam int unsigned SEG_W           = 32;
  localparam int unsigned HV_W            = SEG_W * SEQ_CYCLE_COUNT;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COLLECT   = 2'd1,
    S_WAIT_DONE = 2'd2
  } coll_state_t;

endpackage

// File: rtl/qtz_hv_outbuf.sv
// Single-entry valid/ready holding register for completed hypervectors.
// A load while full and not draining is dropped and flagged on ovf_c.
module qtz_hv_outbuf
  import qtz_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            load,
  input  logic [HV_W-1:0] load_data,
  input  logic            hv_ready,
  output logic            hv_valid,
  output logic [HV_W-1:0] hv_data,
  output logic            ovf_c
);

  assign ovf_c = load & hv_valid & ~hv_ready;

  // A load coincident with a transfer replaces the departing HV.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hv_valid <= 1'b0;
      hv_data  <= '0;
    end else if (load && (!hv_valid || hv_ready)) begin
      hv_valid <= 1'b1;
      hv_data  <= load_data;
    end else if (hv_valid && hv_ready) begin
      hv_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qtz_hv_collector.sv
// Reassembles per-cycle segments from the mapping FSM into full hypervectors
// and hands them downstream through a separate output buffer.
module qtz_hv_collector
  import qtz_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             mapping_hv_segment,
  input  logic [CTR_W-1:0] ctr,
  input  logic [SEG_W-1:0] seg_data,
  input  logic             mapping_done,
  input  logic             err_clr,
  output logic             hv_valid,
  input  logic             hv_ready,
  output logic [HV_W-1:0]  hv_data,
  output logic             busy,
  output logic             seq_err,
  output logic             ovf_err
);

  coll_state_t                         state;
  logic [SEQ_CYCLE_COUNT-1:0]          mask;
  logic [CTR_W-1:0]                    exp_idx;
  logic [SEQ_CYCLE_COUNT-1:0][SEG_W-1:0] asm_buf;

  logic                       cap_c;
  logic                       commit_c;
  logic                       restart_c;
  logic                       seq_evt_c;
  logic                       ovf_evt_c;
  logic [SEQ_CYCLE_COUNT-1:0] mask_base_c;
  logic [SEQ_CYCLE_COUNT-1:0] mask_new_c;
  logic [CTR_W-1:0]           exp_base_c;

  // A segment landing in S_WAIT_DONE starts a fresh assembly from empty.
  always_comb begin
    cap_c       = en & mapping_hv_segment & ~mapping_done;
    commit_c    = mapping_done & (state == S_WAIT_DONE);
    restart_c   = cap_c & (state == S_WAIT_DONE);
    mask_base_c = restart_c ? '0 : mask;
    exp_base_c  = restart_c ? '0 : exp_idx;
    mask_new_c  = mask_base_c | (SEQ_CYCLE_COUNT'(1) << ctr);
    seq_evt_c   = (mapping_done & ~commit_c) | restart_c
                | (cap_c & (ctr != exp_base_c));
  end

  // mapping_done always closes the assembly, either as a commit or an abort.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= S_IDLE;
      mask    <= '0;
      exp_idx <= '0;
      busy    <= 1'b0;
      seq_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      seq_err <= seq_evt_c | (seq_err & ~err_clr);
      ovf_err <= ovf_evt_c | (ovf_err & ~err_clr);
      if (mapping_done) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        mask    <= '0;
        exp_idx <= '0;
      end else if (cap_c) begin
        mask    <= mask_new_c;
        exp_idx <= exp_base_c + CTR_W'(1);
        busy    <= 1'b1;
        state   <= (&mask_new_c) ? S_WAIT_DONE : S_COLLECT;
      end
    end
  end

  // Slot storage needs no reset; mask gates which slots are meaningful.
  always_ff @(posedge clk) begin
    if (cap_c) asm_buf[ctr] <= seg_data;
  end

  qtz_hv_outbuf u_outbuf (
    .clk       (clk),
    .nrst      (nrst),
    .load      (commit_c),
    .load_data (asm_buf),
    .hv_ready  (hv_ready),
    .hv_valid  (hv_valid),
    .hv_data   (hv_data),
    .ovf_c     (ovf_evt_c)
  );

endmodule

// File: tb/tb_qtz_hv_collector.sv
// Scoreboard bench for qtz_hv_collector: directed scenarios plus randomized HV traffic.
module tb_qtz_hv_collector;
  import qtz_pkg::*;

  logic             clk = 1'b0;
  logic             nrst;
  logic             en;
  logic             mapping_hv_segment;
  logic [CTR_W-1:0] ctr;
  logic [SEG_W-1:0] seg_data;
  logic             mapping_done;
  logic             err_clr;
  logic             hv_valid;
  logic             hv_ready;
  logic [HV_W-1:0]  hv_data;
  logic             busy;
  logic             seq_err;
  logic             ovf_err;

  always #5 clk = ~clk;

  qtz_hv_collector dut (
    .clk                (clk),
    .nrst               (nrst),
    .en                 (en),
    .mapping_hv_segment (mapping_hv_segment),
    .ctr                (ctr),
    .seg_data           (seg_data),
    .mapping_done       (mapping_done),
    .err_clr            (err_clr),
    .hv_valid           (hv_valid),
    .hv_ready           (hv_ready),
    .hv_data            (hv_data),
    .busy               (busy),
    .seq_err            (seq_err),
    .ovf_err            (ovf_err)
  );

  logic [HV_W-1:0] exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  bit  exp_seq = 1'b0;
  bit  exp_ovf = 1'b0;
  bit  rnd_ready = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, req);
  endtask

  task automatic chkv(input string nm, input logic [HV_W-1:0] act, input logic [HV_W-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  task automatic chki(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, req);
  endtask

  // Every valid&ready handshake must deliver the oldest expected HV.
  always @(negedge clk) begin
    if (nrst === 1'b1 && hv_valid === 1'b1 && hv_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL xfer_unexpected: got transfer of %h want no transfer", hv_data);
      end else begin
        chkv("xfer_data", hv_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_ready) hv_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [HV_W-1:0] rnd_hv();
    logic [HV_W-1:0] v;
    for (int k = 0; k < SEQ_CYCLE_COUNT; k++) v[k*SEG_W +: SEG_W] = $urandom;
    return v;
  endfunction

  // Sends nseg segments in the given slot order, gap idle cycles, then mapping_done.
  // Returns one cycle after the mapping_done edge.
  task automatic send_hv(input logic [HV_W-1:0] hv, input int ord[SEQ_CYCLE_COUNT],
                         input int nseg, input int gap, input int rdy_done);
    bit inorder = 1'b1;
    for (int i = 0; i < nseg; i++) begin
      mapping_hv_segment = 1'b1;
      ctr                = CTR_W'(ord[i]);
      seg_data           = hv[ord[i]*SEG_W +: SEG_W];
      if (ord[i] != i) inorder = 1'b0;
      cyc();
    end
    mapping_hv_segment = 1'b0;
    for (int i = 0; i < gap; i++) cyc();
    mapping_done = 1'b1;
    if (rdy_done >= 0) hv_ready = rdy_done[0];
    if (nseg != SEQ_CYCLE_COUNT || !inorder) exp_seq = 1'b1;
    if (nseg == SEQ_CYCLE_COUNT) begin
      if (exp_q.size() == 0 || hv_ready) exp_q.push_back(hv);
      else exp_ovf = 1'b1;
    end
    cyc();
    mapping_done = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    exp_seq = 1'b0;
    exp_ovf = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ord_id[SEQ_CYCLE_COUNT];
    int ord_sw[SEQ_CYCLE_COUNT];
    int ord_r[SEQ_CYCLE_COUNT];
    logic [HV_W-1:0] h1, h2, h3;

    for (int i = 0; i < SEQ_CYCLE_COUNT; i++) ord_id[i] = i;
    ord_sw = '{0, 1, 3, 2};

    nrst = 1'b0; en = 1'b1; mapping_hv_segment = 1'b0; ctr = '0; seg_data = '0;
    mapping_done = 1'b0; err_clr = 1'b0; hv_ready = 1'b0;
    repeat (2) cyc();
    chk1("rst_valid", hv_valid, 1'b0);
    chkv("rst_data", hv_data, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_seq", seq_err, 1'b0);
    chk1("rst_ovf", ovf_err, 1'b0);
    nrst = 1'b1;
    cyc();

    // Basic in-order HV with a gap before mapping_done.
    hv_ready = 1'b1;
    h1 = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    send_hv(h1, ord_id, 4, 1, -1);
    chk1("t1_valid", hv_valid, 1'b1);
    chkv("t1_data", hv_data, h1);
    chk1("t1_busy", busy, 1'b0);
    cyc();
    chk1("t1_valid_fall", hv_valid, 1'b0);
    chk1("t1_seq", seq_err, 1'b0);
    chk1("t1_ovf", ovf_err, 1'b0);

    // Output held while downstream stalls; second HV overflows.
    hv_ready = 1'b0;
    h1 = rnd_hv(); h2 = rnd_hv();
    send_hv(h1, ord_id, 4, 1, -1);
    chk1("t2_valid", hv_valid, 1'b1);
    send_hv(h2, ord_id, 4, 1, -1);
    chk1("t2_ovf", ovf_err, 1'b1);
    chkv("t2_hold", hv_data, h1);
    hv_ready = 1'b1;
    cyc();
    chk1("t2_valid_fall", hv_valid, 1'b0);
    clear_errs();
    chk1("t2_ovf_clr", ovf_err, 1'b0);

    // Transfer coincident with the next commit.
    hv_ready = 1'b0;
    h1 = rnd_hv(); h2 = rnd_hv();
    send_hv(h1, ord_id, 4, 1, -1);
    send_hv(h2, ord_id, 4, 1, 1);
    chk1("t3_valid", hv_valid, 1'b1);
    chkv("t3_data", hv_data, h2);
    chk1("t3_ovf", ovf_err, 1'b0);
    cyc();
    chk1("t3_valid_fall", hv_valid, 1'b0);

    // Out-of-order indices still land in their slots.
    h1 = rnd_hv();
    send_hv(h1, ord_sw, 4, 1, -1);
    chk1("t4_seq", seq_err, 1'b1);
    chkv("t4_data", hv_data, h1);
    cyc();
    clear_errs();
    chk1("t4_seq_clr", seq_err, 1'b0);

    // Early mapping_done aborts; next HV is clean.
    h1 = rnd_hv();
    send_hv(h1, ord_id, 2, 1, -1);
    chk1("t5_seq", seq_err, 1'b1);
    chk1("t5_valid", hv_valid, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    clear_errs();
    h2 = rnd_hv();
    send_hv(h2, ord_id, 4, 0, -1);
    chkv("t5_next_data", hv_data, h2);
    chk1("t5_next_seq", seq_err, 1'b0);
    cyc();

    // Segments ignored while disabled.
    en = 1'b0;
    for (int i = 0; i < SEQ_CYCLE_COUNT; i++) begin
      mapping_hv_segment = 1'b1; ctr = CTR_W'(i); seg_data = $urandom;
      cyc();
    end
    mapping_hv_segment = 1'b0;
    chk1("en_busy", busy, 1'b0);
    en = 1'b1;

    // Reset mid-assembly with an HV held.
    hv_ready = 1'b0;
    h1 = rnd_hv();
    send_hv(h1, ord_id, 4, 1, -1);
    for (int i = 0; i < 2; i++) begin
      mapping_hv_segment = 1'b1; ctr = CTR_W'(i); seg_data = $urandom;
      cyc();
    end
    mapping_hv_segment = 1'b0;
    chk1("t6_busy_pre", busy, 1'b1);
    nrst = 1'b0;
    exp_q.delete();
    cyc();
    chk1("t6_valid", hv_valid, 1'b0);
    chkv("t6_data", hv_data, '0);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_seq", seq_err, 1'b0);
    chk1("t6_ovf", ovf_err, 1'b0);
    nrst = 1'b1; exp_seq = 1'b0; exp_ovf = 1'b0; hv_ready = 1'b1;
    cyc();
    h3 = rnd_hv();
    send_hv(h3, ord_id, 4, 1, -1);
    chkv("t6_next_data", hv_data, h3);
    cyc();

    // Randomized traffic with random downstream backpressure.
    rnd_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int nseg;
      ord_r = ord_id;
      if ($urandom_range(0, 3) == 0) begin
        for (int i = SEQ_CYCLE_COUNT - 1; i > 0; i--) begin
          int j;
          int t;
          j = $urandom_range(0, i);
          t = ord_r[i]; ord_r[i] = ord_r[j]; ord_r[j] = t;
        end
      end
      nseg = ($urandom_range(0, 5) == 0) ? $urandom_range(1, SEQ_CYCLE_COUNT - 1) : SEQ_CYCLE_COUNT;
      send_hv(rnd_hv(), ord_r, nseg, $urandom_range(0, 2), -1);
      chk1("rnd_seq", seq_err, exp_seq);
      chk1("rnd_ovf", ovf_err, exp_ovf);
      if ($urandom_range(0, 2) == 0) clear_errs();
    end

    rnd_ready = 1'b0;
    hv_ready  = 1'b1;
    repeat (3) cyc();
    chki("drain_empty", exp_q.size(), 0);
    chk1("drain_valid", hv_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
